// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the common data bus among NUM_REQ result producers.
// Each producer owns a one-deep holding slot; one winner per cycle drives the registered CDB.
module cdb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_data,
    output logic [SRC_W-1:0]          cdb_src
);

    logic [NUM_REQ-1:0]             slot_v_q, slot_v_d;
    logic [NUM_REQ-1:0][TAG_W-1:0]  slot_tag_q, slot_tag_d;
    logic [NUM_REQ-1:0][DATA_W-1:0] slot_data_q, slot_data_d;
    logic [SRC_W-1:0]               rr_ptr_q, rr_ptr_d;

    logic                           cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]               cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]              cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]               cdb_src_q, cdb_src_d;

    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             accept;
    logic                           grant_any;
    logic [SRC_W-1:0]               win_idx;
    logic [SRC_W-1:0]               cand;

    // Search upward from rr_ptr with wrap; only registered slot_v takes part, so a slot
    // loaded this cycle can never win until the next one.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = SRC_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_any && !flush && slot_v_q[cand]) begin
                grant_any = 1'b1;
                win_idx   = cand;
            end
        end
        if (grant_any) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign req_ready = flush ? '0 : (~slot_v_q | grant);
    assign accept    = req_valid & req_ready;

    always_comb begin
        slot_v_d    = slot_v_q;
        slot_tag_d  = slot_tag_q;
        slot_data_d = slot_data_q;
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;

        if (flush) begin
            slot_v_d = '0;
        end else begin
            // A refill in the grant cycle wins over the clear.
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (accept[i]) begin
                    slot_v_d[i]    = 1'b1;
                    slot_tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
                    slot_data_d[i] = req_data[i*DATA_W +: DATA_W];
                end else if (grant[i]) begin
                    slot_v_d[i] = 1'b0;
                end
            end

            if (grant_any) begin
                cdb_valid_d = 1'b1;
                cdb_tag_d   = slot_tag_q[win_idx];
                cdb_data_d  = slot_data_q[win_idx];
                cdb_src_d   = win_idx;
                rr_ptr_d    = (win_idx == SRC_W'(NUM_REQ - 1)) ? '0 : win_idx + SRC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_v_q    <= '0;
            slot_tag_q  <= '0;
            slot_data_q <= '0;
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            slot_v_q    <= slot_v_d;
            slot_tag_q  <= slot_tag_d;
            slot_data_q <= slot_data_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single producer, contention, pointer wrap,
// same-cycle drain/refill and flush, with hand-computed expectations.
module tb_cdb_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 6;
    localparam int DATA_W  = 32;
    localparam int SRC_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic                      flush = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*TAG_W-1:0]  req_tag = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      cdb_valid;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_data;
    logic [SRC_W-1:0]          cdb_src;

    int n_checks = 0;
    int n_fail   = 0;

    cdb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .cdb_src   (cdb_src)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        req_valid[i]                 = 1'b1;
        req_tag[i*TAG_W +: TAG_W]    = t;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rdy;

        // Reset held 3 cycles with every producer requesting
        reset = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 6'(8'h10 + i), 32'hA000_0000 + i);
        for (int c = 0; c < 3; c++) begin
            tick;
            check_eq("rst_valid", cdb_valid, 0);
        end
        check_eq("rst_tag", cdb_tag, 0);
        check_eq("rst_data", cdb_data, 0);
        check_eq("rst_src", cdb_src, 0);
        reset     = 1'b0;
        req_valid = '0;
        #1;
        check_eq("rst_ready", req_ready, 4'hF);
        tick;
        check_eq("rst_noload1", cdb_valid, 0);
        tick;
        check_eq("rst_noload2", cdb_valid, 0);

        // Single producer: two edges from accept to broadcast
        set_req(2, 6'h05, 32'hDEAD_BEEF);
        tick;
        req_valid = '0;
        check_eq("single_lat", cdb_valid, 0);
        tick;
        check_eq("single_valid", cdb_valid, 1);
        check_eq("single_tag", cdb_tag, 6'h05);
        check_eq("single_data", cdb_data, 32'hDEAD_BEEF);
        check_eq("single_src", cdb_src, 2);
        tick;
        check_eq("single_pulse", cdb_valid, 0);
        check_eq("single_hold", cdb_tag, 6'h05);

        // Full contention from rr_ptr = 0
        do_reset;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 6'(8'h10 + i), 32'hA000_0000 + i);
        tick;
        check_eq("fc_first_valid", cdb_valid, 0);
        check_eq("fc_first_ready", req_ready, 4'b0001);
        for (int c = 0; c < 8; c++) begin
            tick;
            check_eq("fc_valid", cdb_valid, 1);
            check_eq("fc_src", cdb_src, 64'(c % 4));
            check_eq("fc_tag", cdb_tag, 64'(8'h10 + (c % 4)));
            check_eq("fc_data", cdb_data, 64'(32'hA000_0000 + (c % 4)));
            exp_rdy = 4'(1 << ((c + 1) % 4));
            check_eq("fc_ready", req_ready, exp_rdy);
        end

        // Pointer skip/wrap: move rr_ptr to 2, then slots 1 and 3
        do_reset;
        set_req(1, 6'h01, 32'h1);
        tick;
        req_valid = '0;
        tick;
        check_eq("ptr_pre_src", cdb_src, 1);
        set_req(1, 6'h21 + 6'h20, 32'h41);
        set_req(3, 6'h03 + 6'h40, 32'h43);
        tick;
        req_valid = '0;
        check_eq("ptr_ready", req_ready, 4'b1101);
        tick;
        check_eq("ptr_g3_valid", cdb_valid, 1);
        check_eq("ptr_g3_src", cdb_src, 3);
        check_eq("ptr_g3_tag", cdb_tag, 6'h03);
        check_eq("ptr_g3_ready", req_ready, 4'hF);
        tick;
        check_eq("ptr_g1_src", cdb_src, 1);
        check_eq("ptr_g1_tag", cdb_tag, 6'h01);
        tick;
        check_eq("ptr_idle", cdb_valid, 0);
        // rr_ptr should now be 2, so slot 2 beats slot 0
        set_req(0, 6'h10, 32'h50);
        set_req(2, 6'h12, 32'h52);
        tick;
        req_valid = '0;
        tick;
        check_eq("ptr_end_src_a", cdb_src, 2);
        check_eq("ptr_end_data_a", cdb_data, 32'h52);
        tick;
        check_eq("ptr_end_src_b", cdb_src, 0);

        // Same-cycle drain and refill on producer 0
        do_reset;
        set_req(0, 6'h01, 32'h101);
        tick;
        check_eq("dr_ready0", req_ready[0], 1);
        set_req(0, 6'h02, 32'h102);
        tick;
        check_eq("dr_tag1", cdb_tag, 6'h01);
        check_eq("dr_valid1", cdb_valid, 1);
        check_eq("dr_ready1", req_ready[0], 1);
        set_req(0, 6'h03, 32'h103);
        tick;
        check_eq("dr_tag2", cdb_tag, 6'h02);
        check_eq("dr_valid2", cdb_valid, 1);
        req_valid = '0;
        tick;
        check_eq("dr_tag3", cdb_tag, 6'h03);
        check_eq("dr_data3", cdb_data, 32'h103);
        tick;
        check_eq("dr_idle", cdb_valid, 0);

        // Flush with slots 0, 1, 3 loaded
        do_reset;
        set_req(0, 6'h20, 32'h200);
        set_req(1, 6'h21, 32'h201);
        set_req(3, 6'h23, 32'h203);
        tick;
        req_valid = '0;
        flush     = 1'b1;
        #1;
        check_eq("fl_ready", req_ready, 4'h0);
        tick;
        flush = 1'b0;
        check_eq("fl_valid", cdb_valid, 0);
        for (int c = 0; c < 4; c++) begin
            tick;
            check_eq("fl_quiet", cdb_valid, 0);
        end
        check_eq("fl_tag_untouched", cdb_tag, 0);
        set_req(1, 6'h30, 32'h300);
        tick;
        req_valid = '0;
        check_eq("fl_new_lat", cdb_valid, 0);
        tick;
        check_eq("fl_new_valid", cdb_valid, 1);
        check_eq("fl_new_tag", cdb_tag, 6'h30);
        check_eq("fl_new_src", cdb_src, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among `NUM_REQ` functional-unit result producers: the ALU instances inside the FU unit wrapper plus future load/store and multiply units. Each producer's result is captured in a per-requester holding slot. One winner per cycle is driven onto a registered CDB broadcast, which feeds the reservation stations, ROB and register-status logic. A flush input drops all buffered and in-flight results on branch mispredict.

## Interface
Parameters:
- `NUM_REQ`, 4: number of result producers (≥2).
- `TAG_W`, 6: physical-register / ROB tag width.
- `DATA_W`, 32: result data width.
- `SRC_W`, `$clog2(NUM_REQ)`: winner-index width (derived).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `flush`  in  1: synchronous squash of all pending results.
- `req_valid`  in  NUM_REQ: producer i presents a result.
- `req_tag`  in  NUM_REQ*TAG_W: packed tags; slice i at [i*TAG_W +: TAG_W].
- `req_data`  in  NUM_REQ*DATA_W: packed results, same packing.
- `req_ready`  out  NUM_REQ: slot i can accept this cycle.
- `cdb_valid`  out  1: broadcast valid.
- `cdb_tag`  out  TAG_W: broadcast tag.
- `cdb_data`  out  DATA_W: broadcast data.
- `cdb_src`  out  SRC_W: index of the producer that won.

## Operation
- Per-requester slot: `slot_v[i]`, `slot_tag[i]`, `slot_data[i]`. Depth is 1.
- `req_ready[i] = !slot_v[i] || grant[i]`. This is combinational, so a slot drained this cycle may refill in the same cycle.
- Accept condition: `req_valid[i] && req_ready[i]` at a rising edge. The slot loads tag and data and `slot_v[i]` becomes 1.
- Arbitration is combinational over `slot_v`. It is round-robin starting at pointer `rr_ptr` and searching upward with wrap from NUM_REQ-1 to 0. The first set slot wins and `grant` is one-hot or zero.
- Granted slot behaviour:
  - Its contents load into the CDB output registers.
  - The slot clears unless it is refilled that cycle; refill takes precedence over clear.
  - `rr_ptr` ← winner+1, wrapping to 0 after NUM_REQ-1.
- No grant: `cdb_valid` ← 0, `rr_ptr` is held, and tag, data and src hold their previous values.
- A slot is never granted in the cycle it is loaded. Arbitration uses registered `slot_v` only.
- Flush effects, taken in the flush cycle:
  - All `slot_v` ← 0.
  - `cdb_valid` ← 0.
  - No grant is issued.
  - `req_ready` = 0 for all requesters, so nothing is accepted.
  - `rr_ptr` is held.
- `reset` has priority over `flush`.

## Timing
- Reset values:
  - `slot_v` = 0, `rr_ptr` = 0.
  - `cdb_valid` = 0, `cdb_tag` = 0, `cdb_data` = 0, `cdb_src` = 0.
  - `req_ready` = all 1s after reset, because the slots are empty and flush is low.
- Latency, uncontended: accept at edge N → granted during cycle N → `cdb_valid` = 1 after edge N+1. That is 2 edges from acceptance to broadcast.
- Throughput is one CDB broadcast per cycle total. Each producer can sustain 1 result per cycle only when uncontended.
- Starvation bound: a valid slot is granted within NUM_REQ cycles.
- `cdb_valid` is a single-cycle pulse per result. Consumers do not backpressure the CDB.
- If a producer holds `req_valid` while `req_ready` = 0, its data must stay stable until accepted. The block does not check this.
- Reset or flush asserted mid-broadcast: `cdb_valid` drops at the next edge. A result being granted in that cycle is lost by design.
- All outputs except `req_ready` are registered.

## Test plan
- **Reset:** hold reset for 3 cycles with all `req_valid` = 1 → `cdb_valid` = 0 throughout, and `req_ready` = 4'b1111 after reset deasserts. No slot is loaded during reset.
- **Single producer:** req 2 sends tag 0x05, data 0xDEADBEEF at edge N → after N+1, `cdb_valid` = 1, tag = 0x05, data = 0xDEADBEEF, src = 2. `cdb_valid` is 0 after N+2.
- **Full contention:** all 4 producers valid every cycle with distinct tags 0x10..0x13, `rr_ptr` = 0 → `cdb_src` sequence is 0,1,2,3,0,1… Back-to-back `cdb_valid`, no starvation, and each `req_ready[i]` is high only in its grant cycle.
- **Pointer wrap / skip:** only slots 1 and 3 valid, `rr_ptr` = 2 → grant 3 then 1. `rr_ptr` ends at 2.
- **Same-cycle drain and refill:** req 0 valid continuously with tags 0x01, 0x02, 0x03 and no other requesters → results broadcast on consecutive cycles. `req_ready[0]` stays 1.
- **Flush:** slots 0, 1 and 3 loaded, assert flush for 1 cycle → `cdb_valid` = 0 on the next edge and stays 0. No queued tag (0x20, 0x21, 0x23) ever appears. A new req 1 tag 0x30 after flush broadcasts normally 2 edges later.
